// File: rtl/i2c_pkg.sv
// i2c_pkg: shared definitions for the I2C configuration sequencer.
// Optional feature macro: I2C_READBACK_VERIFY_EN adds the readback-verify states.
package i2c_pkg;

    // Table entry that terminates the walk.
    localparam logic [15:0] END_MARKER = 16'hFFFF;
    // Register byte that marks a delay entry instead of a write.
    localparam logic [7:0]  DELAY_REG  = 8'hFE;

    // Sequencer state encoding.
    typedef enum logic [3:0] {
        ST_IDLE          = 4'd0,
        ST_FETCH         = 4'd1,
        ST_DECODE        = 4'd2,
        ST_ISSUE         = 4'd3,
        ST_WAIT_ACCEPT   = 4'd4,
        ST_WAIT_DONE     = 4'd5,
        ST_CHECK         = 4'd6,
        ST_DELAY         = 4'd7,
        ST_DONE          = 4'd8,
`ifdef I2C_READBACK_VERIFY_EN
        ST_ERROR         = 4'd9,
        ST_VERIFY_ISSUE  = 4'd10,
        ST_VERIFY_ACCEPT = 4'd11,
        ST_VERIFY_DONE   = 4'd12,
        ST_VERIFY_CHECK  = 4'd13
`else
        ST_ERROR         = 4'd9
`endif
    } state_t;

    // Bits needed to address 'value' distinct items; never returns less than 1.
    function automatic int clog2(input int value);
        int width;
        width = 1;
        while ((1 << width) < value) begin
            width = width + 1;
        end
        return width;
    endfunction

endpackage

// File: rtl/i2c_config_sequencer_if.sv
// i2c_config_sequencer_if: command port between the sequencer and the I2C master.
// Optional feature macro: I2C_READBACK_VERIFY_EN adds i2cStartRead / i2cDataOut.
//
// Handshake: i2cStartWrite (or i2cStartRead) is a one-cycle request that carries
// i2cAddress/i2cReg/i2cData. The master accepts it by raising i2cBusy, possibly
// one cycle late, and completes it by dropping i2cBusy; from that cycle on
// i2cAckError (and i2cDataOut for a read) are valid. The requester never issues
// a new request while i2cBusy=1.
interface i2c_config_sequencer_if;

    logic       i2cStartWrite;
    logic [6:0] i2cAddress;
    logic [7:0] i2cReg;
    logic [7:0] i2cData;
    logic       i2cBusy;
    logic       i2cAckError;
`ifdef I2C_READBACK_VERIFY_EN
    logic       i2cStartRead;
    logic [7:0] i2cDataOut;

    modport master (
        output i2cStartWrite, i2cAddress, i2cReg, i2cData, i2cStartRead,
        input  i2cBusy, i2cAckError, i2cDataOut
    );

    modport slave (
        input  i2cStartWrite, i2cAddress, i2cReg, i2cData, i2cStartRead,
        output i2cBusy, i2cAckError, i2cDataOut
    );
`else
    modport master (
        output i2cStartWrite, i2cAddress, i2cReg, i2cData,
        input  i2cBusy, i2cAckError
    );

    modport slave (
        input  i2cStartWrite, i2cAddress, i2cReg, i2cData,
        output i2cBusy, i2cAckError
    );
`endif

endinterface

// File: rtl/i2c_delay_timer.sv
// i2c_delay_timer: loadable down-counter used for delay table entries.
// After a load, 'expired' rises once COUNT cycles have been spent waiting
// (counting the first cycle after the load as cycle one).
module i2c_delay_timer
    import i2c_pkg::*;
#(
    parameter int COUNT = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    output logic expired
);

    localparam int LOAD_VALUE = (COUNT > 1) ? COUNT - 1 : 0;
    localparam int CW         = clog2(LOAD_VALUE + 1);

    logic [CW-1:0] count;

    // Load the full count, then step down to zero and hold there.
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= CW'(LOAD_VALUE);
        end else if (count != '0) begin
            count <= count - CW'(1);
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/i2c_config_sequencer.sv
// i2c_config_sequencer: walks a (reg, data) table held in a synchronous ROM and
// issues one single-byte I2C write per entry to DEVICE_ADDRESS, with ACK-error
// retries, delay entries and end-of-table detection.
// Optional feature macro: I2C_READBACK_VERIFY_EN reads every written register
// back and treats a NACK or a data difference as a failed attempt.
module i2c_config_sequencer
    import i2c_pkg::*;
#(
    parameter int         CLOCK_FREQUENCY = 12000000,
    parameter logic [6:0] DEVICE_ADDRESS  = 7'h21,
    parameter int         NR_OF_ENTRIES   = 64,
    parameter int         MAX_RETRIES     = 3,
    parameter int         DELAY_MS        = 10,
    localparam int        IW              = clog2(NR_OF_ENTRIES)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    output logic                  seqBusy,
    output logic                  done,
    output logic                  error,
    output logic [IW-1:0]         errorIndex,
    output logic [IW-1:0]         tableIndex,
    input  logic [15:0]           tableEntry,
    output state_t                debug_state,
    i2c_config_sequencer_if.master bus
);

    localparam int RW           = clog2(MAX_RETRIES + 1);
    localparam int DELAY_CYCLES = DELAY_MS * CLOCK_FREQUENCY / 1000;

    state_t        state, state_next;
    logic [IW-1:0] index, index_next;
    logic [RW-1:0] retries, retries_next;
    logic [7:0]    reg_q, reg_next;
    logic [7:0]    data_q, data_next;
    logic          error_q, error_next;
    logic [IW-1:0] error_index_q, error_index_next;
    logic          timer_load;
    logic          timer_expired;
    logic          advance;
    logic          fail_attempt;
    logic          last_entry;
    logic          retry_left;

    assign last_entry = (index == IW'(NR_OF_ENTRIES - 1));
    assign retry_left = (retries < RW'(MAX_RETRIES));

    i2c_delay_timer #(
        .COUNT(DELAY_CYCLES)
    ) u_delay_timer (
        .clock  (clock),
        .reset  (reset),
        .load   (timer_load),
        .expired(timer_expired)
    );

    // State and datapath registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= ST_IDLE;
            index         <= '0;
            retries       <= '0;
            reg_q         <= '0;
            data_q        <= '0;
            error_q       <= 1'b0;
            error_index_q <= '0;
        end else begin
            state         <= state_next;
            index         <= index_next;
            retries       <= retries_next;
            reg_q         <= reg_next;
            data_q        <= data_next;
            error_q       <= error_next;
            error_index_q <= error_index_next;
        end
    end

    // Next-state logic; a finished entry raises 'advance', a failed attempt
    // raises 'fail_attempt', and both are resolved after the case.
    always_comb begin
        state_next       = state;
        index_next       = index;
        retries_next     = retries;
        reg_next         = reg_q;
        data_next        = data_q;
        error_next       = error_q;
        error_index_next = error_index_q;
        timer_load       = 1'b0;
        advance          = 1'b0;
        fail_attempt     = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    error_next   = 1'b0;
                    index_next   = '0;
                    retries_next = '0;
                    state_next   = ST_FETCH;
                end
            end
            ST_FETCH: state_next = ST_DECODE;
            ST_DECODE: begin
                if (tableEntry == END_MARKER) begin
                    state_next = ST_DONE;
                end else if (tableEntry[15:8] == DELAY_REG) begin
                    timer_load = 1'b1;
                    state_next = ST_DELAY;
                end else begin
                    reg_next   = tableEntry[15:8];
                    data_next  = tableEntry[7:0];
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: state_next = ST_WAIT_ACCEPT;
            ST_WAIT_ACCEPT: begin
                if (bus.i2cBusy) state_next = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (!bus.i2cBusy) state_next = ST_CHECK;
            end
`ifdef I2C_READBACK_VERIFY_EN
            ST_CHECK: begin
                if (!bus.i2cAckError) state_next = ST_VERIFY_ISSUE;
                else                  fail_attempt = 1'b1;
            end
            ST_VERIFY_ISSUE: state_next = ST_VERIFY_ACCEPT;
            ST_VERIFY_ACCEPT: begin
                if (bus.i2cBusy) state_next = ST_VERIFY_DONE;
            end
            ST_VERIFY_DONE: begin
                if (!bus.i2cBusy) state_next = ST_VERIFY_CHECK;
            end
            ST_VERIFY_CHECK: begin
                if (!bus.i2cAckError && (bus.i2cDataOut == data_q)) advance = 1'b1;
                else                                                fail_attempt = 1'b1;
            end
`else
            ST_CHECK: begin
                if (!bus.i2cAckError) advance = 1'b1;
                else                  fail_attempt = 1'b1;
            end
`endif
            ST_DELAY: begin
                if (timer_expired) advance = 1'b1;
            end
            ST_DONE:  state_next = ST_IDLE;
            ST_ERROR: state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase

        if (fail_attempt) begin
            if (retry_left) begin
                retries_next = retries + RW'(1);
                state_next   = ST_ISSUE;
            end else begin
                error_next       = 1'b1;
                error_index_next = index;
                state_next       = ST_ERROR;
            end
        end

        // The last table slot ends the run even without an end marker.
        if (advance) begin
            retries_next = '0;
            if (last_entry) begin
                state_next = ST_DONE;
            end else begin
                index_next = index + IW'(1);
                state_next = ST_FETCH;
            end
        end
    end

    assign seqBusy           = (state != ST_IDLE);
    assign done              = (state == ST_DONE);
    assign error             = error_q;
    assign errorIndex        = error_index_q;
    assign tableIndex        = index;
    assign debug_state       = state;
    assign bus.i2cStartWrite = (state == ST_ISSUE);
    assign bus.i2cAddress    = DEVICE_ADDRESS;
    assign bus.i2cReg        = reg_q;
    assign bus.i2cData       = data_q;
`ifdef I2C_READBACK_VERIFY_EN
    assign bus.i2cStartRead  = (state == ST_VERIFY_ISSUE);
`endif

endmodule

// File: tb/tb_i2c_config_sequencer.sv
// tb_i2c_config_sequencer: directed vector table, hand-written corner sequences
// and randomized tables checked against a table-walk reference model.
module tb_i2c_config_sequencer;
    import i2c_pkg::*;

    localparam int NR   = 8;
    localparam int IW   = clog2(NR);
    localparam int MAXR = 3;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          seqBusy, done, error;
    logic [IW-1:0] errorIndex, tableIndex;
    logic [15:0]   tableEntry;
    state_t        debug_state;

    i2c_config_sequencer_if bus();

    i2c_config_sequencer #(
        .CLOCK_FREQUENCY(12000000),
        .DEVICE_ADDRESS (7'h21),
        .NR_OF_ENTRIES  (NR),
        .MAX_RETRIES    (MAXR),
        .DELAY_MS       (1)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .seqBusy    (seqBusy),
        .done       (done),
        .error      (error),
        .errorIndex (errorIndex),
        .tableIndex (tableIndex),
        .tableEntry (tableEntry),
        .debug_state(debug_state),
        .bus        (bus.master)
    );

    // clock
    always #5 clock = ~clock;

    // synchronous table ROM
    logic [15:0] rom [NR];
    always @(posedge clock) tableEntry <= rom[tableIndex];

    int          n_vec = 0;
    int          n_bad = 0;
    int          fails_left [NR];
    int          corrupt_left [NR];
    int          write_cnt, read_cnt, done_cnt;
    int          busy_lo = 0, busy_hi = 3;
    logic [15:0] obs_q[$];
    logic [15:0] exp_q[$];
    time         t_start;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // I2C master model and output monitor, evaluated away from the active edge
    initial begin
        logic pending;
        int   busy_left;
        logic nack_now;
        pending = 1'b0; busy_left = 0; nack_now = 1'b0;
        bus.i2cBusy = 1'b0; bus.i2cAckError = 1'b0;
`ifdef I2C_READBACK_VERIFY_EN
        bus.i2cDataOut = 8'h00;
`endif
        forever begin
            @(negedge clock);
            if (reset) begin
                bus.i2cBusy = 1'b0; bus.i2cAckError = 1'b0; pending = 1'b0;
            end else begin
                if (done) done_cnt++;
                if (pending) begin
                    bus.i2cBusy = 1'b1; pending = 1'b0;
                end else if (bus.i2cBusy) begin
                    if (busy_left == 0) begin
                        bus.i2cBusy = 1'b0; bus.i2cAckError = nack_now;
                    end else busy_left--;
                end
                if (bus.i2cStartWrite) begin
                    obs_q.push_back({bus.i2cReg, bus.i2cData});
                    write_cnt++;
                    pending = 1'b1; bus.i2cAckError = 1'b0;
                    busy_left = int'($urandom_range(busy_hi, busy_lo));
                    nack_now = (fails_left[tableIndex] > 0);
                    if (nack_now) fails_left[tableIndex]--;
                end
`ifdef I2C_READBACK_VERIFY_EN
                if (bus.i2cStartRead) begin
                    read_cnt++;
                    pending = 1'b1; bus.i2cAckError = 1'b0; nack_now = 1'b0;
                    busy_left = int'($urandom_range(busy_hi, busy_lo));
                    if (corrupt_left[tableIndex] > 0) begin
                        bus.i2cDataOut = 8'h00; corrupt_left[tableIndex]--;
                    end else bus.i2cDataOut = bus.i2cData;
                end
`endif
            end
        end
    end

    // driver tasks
    task automatic load(input logic [NR-1:0][15:0] r);
        for (int i = 0; i < NR; i++) begin
            rom[i] = r[i]; fails_left[i] = 0; corrupt_left[i] = 0;
        end
        obs_q.delete(); write_cnt = 0; read_cnt = 0; done_cnt = 0;
    endtask

    task automatic pulse_start();
        @(negedge clock); #1 start = 1'b1; t_start = $time;
        @(negedge clock); #1 start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while (seqBusy && n < budget) begin
            @(negedge clock); #1; n++;
        end
        check({name, "_timeout"}, 32'(seqBusy), 0);
        @(negedge clock); #1;
    endtask

    task automatic run(input int budget, input string name);
        pulse_start();
        wait_idle(budget, name);
    endtask

    task automatic wait_state(input state_t s, input int budget, input string name);
        int n = 0;
        while (debug_state != s && n < budget) begin
            @(negedge clock); #1; n++;
        end
        check({name, "_reach_state"}, 32'(debug_state), 32'(s));
    endtask

    task automatic check_reset_outputs(input string p);
        check({p, "_seqBusy"}, 32'(seqBusy), 0);
        check({p, "_done"}, 32'(done), 0);
        check({p, "_error"}, 32'(error), 0);
        check({p, "_errorIndex"}, 32'(errorIndex), 0);
        check({p, "_tableIndex"}, 32'(tableIndex), 0);
        check({p, "_startWrite"}, 32'(bus.i2cStartWrite), 0);
        check({p, "_i2cReg"}, 32'(bus.i2cReg), 0);
        check({p, "_i2cData"}, 32'(bus.i2cData), 0);
        check({p, "_i2cAddress"}, 32'(bus.i2cAddress), 32'h21);
        check({p, "_state_idle"}, 32'(debug_state), 32'(ST_IDLE));
    endtask

    // reference model: walk the table by the sequencing rules (no delay entries)
    logic [15:0] m_rom [NR];
    int          m_fail [NR];
    logic        m_done, m_err;
    int          m_idx;
    task automatic model_walk();
        int n;
        exp_q.delete(); m_done = 1'b0; m_err = 1'b0; m_idx = 0;
        for (int i = 0; i < NR; i++) begin
            if (m_rom[i] == 16'hFFFF) begin m_done = 1'b1; break; end
            n = (m_fail[i] > MAXR) ? MAXR + 1 : m_fail[i] + 1;
            for (int k = 0; k < n; k++) exp_q.push_back(m_rom[i]);
            if (m_fail[i] > MAXR) begin m_err = 1'b1; m_idx = i; break; end
            if (i == NR - 1) m_done = 1'b1;
        end
    endtask

    // directed vectors
    typedef struct packed {
        logic [NR-1:0][15:0] tbl;
        logic [IW-1:0]       fail_idx;
        logic [3:0]          fail_n;
        logic [7:0]          n_writes;
        logic [15:0]         first_w;
        logic [15:0]         last_w;
        logic                exp_done;
        logic                exp_err;
        logic [IW-1:0]       err_idx;
    } vec_t;

    function automatic logic [NR-1:0][15:0] t8(input logic [15:0] a0, a1, a2, a3, a4, a5, a6, a7);
        logic [NR-1:0][15:0] r;
        r[0] = a0; r[1] = a1; r[2] = a2; r[3] = a3; r[4] = a4; r[5] = a5; r[6] = a6; r[7] = a7;
        return r;
    endfunction

    vec_t vecs [8];

    initial begin
        for (int i = 0; i < NR; i++) begin
            rom[i] = 16'h0000; fails_left[i] = 0; corrupt_left[i] = 0;
        end
        write_cnt = 0; read_cnt = 0; done_cnt = 0;

        vecs[0] = '{t8(16'h1280, 16'h1101, 16'hFFFF, 0, 0, 0, 0, 0), 3'd0, 4'd0, 8'd2, 16'h1280, 16'h1101, 1'b1, 1'b0, 3'd0};
        vecs[1] = '{t8(16'h1280, 16'h1101, 16'h2233, 16'hFFFF, 0, 0, 0, 0), 3'd1, 4'd2, 8'd5, 16'h1280, 16'h2233, 1'b1, 1'b0, 3'd0};
        vecs[2] = '{t8(16'h1280, 16'h1101, 16'h2233, 16'hFFFF, 0, 0, 0, 0), 3'd2, 4'd9, 8'd6, 16'h1280, 16'h2233, 1'b0, 1'b1, 3'd2};
        vecs[3] = '{t8(16'h1001, 16'h1102, 16'h1203, 16'h1304, 16'h1405, 16'h1506, 16'h1607, 16'h1708), 3'd0, 4'd0, 8'd8, 16'h1001, 16'h1708, 1'b1, 1'b0, 3'd0};
        vecs[4] = '{t8(16'h1280, 16'hFFFF, 0, 0, 0, 0, 0, 0), 3'd0, 4'd3, 8'd4, 16'h1280, 16'h1280, 1'b1, 1'b0, 3'd0};
        vecs[5] = '{t8(16'hFFFF, 16'h1280, 0, 0, 0, 0, 0, 0), 3'd0, 4'd0, 8'd0, 16'h0000, 16'h0000, 1'b1, 1'b0, 3'd0};
        vecs[6] = '{t8(16'h1280, 16'h1101, 16'hFFFF, 0, 0, 0, 0, 0), 3'd0, 4'd4, 8'd4, 16'h1280, 16'h1280, 1'b0, 1'b1, 3'd0};
        vecs[7] = '{t8(16'h2000, 16'h2101, 16'h2202, 16'h2303, 16'h2404, 16'h2505, 16'h2606, 16'hFFFF), 3'd0, 4'd0, 8'd7, 16'h2000, 16'h2606, 1'b1, 1'b0, 3'd0};

        // reset
        reset = 1'b1;
        repeat (4) @(negedge clock);
        #1 check_reset_outputs("reset");
        reset = 1'b0;

        // directed vector table
        for (int v = 0; v < 8; v++) begin
            string nm;
            nm = $sformatf("vec%0d", v);
            load(vecs[v].tbl);
            if (vecs[v].fail_n != 0) fails_left[vecs[v].fail_idx] = int'(vecs[v].fail_n);
            run(1000, nm);
            check({nm, "_writes"}, 32'(write_cnt), 32'(vecs[v].n_writes));
            if (vecs[v].n_writes != 0 && obs_q.size() > 0) begin
                check({nm, "_first"}, 32'(obs_q[0]), 32'(vecs[v].first_w));
                check({nm, "_last"}, 32'(obs_q[obs_q.size() - 1]), 32'(vecs[v].last_w));
            end
            check({nm, "_done_pulses"}, 32'(done_cnt), 32'(vecs[v].exp_done));
            check({nm, "_error"}, 32'(error), 32'(vecs[v].exp_err));
            if (vecs[v].exp_err) check({nm, "_errorIndex"}, 32'(errorIndex), 32'(vecs[v].err_idx));
        end

        // delay entry: first write must wait one millisecond of 12 MHz cycles
        load(t8(16'hFE00, 16'h1234, 16'hFFFF, 0, 0, 0, 0, 0));
        pulse_start();
        begin
            int n = 0;
            while (write_cnt == 0 && n < 13000) begin
                @(negedge clock); #1; n++;
            end
        end
        check("delay_first_write_seen", 32'(write_cnt), 1);
        check("delay_min_cycles", 32'(((($time - t_start) / 10) >= 12000) ? 1 : 0), 1);
        check("delay_max_cycles", 32'(((($time - t_start) / 10) <= 12010) ? 1 : 0), 1);
        wait_idle(1000, "delay");
        if (obs_q.size() > 0) check("delay_write_value", 32'(obs_q[0]), 32'h1234);
        check("delay_done_pulses", 32'(done_cnt), 1);

        // start pulsed while busy is ignored
        load(t8(16'h1280, 16'h1101, 16'hFFFF, 0, 0, 0, 0, 0));
        busy_lo = 4; busy_hi = 6;
        pulse_start();
        wait_state(ST_WAIT_DONE, 50, "busy_start");
        pulse_start();
        wait_idle(1000, "busy_start");
        check("busy_start_writes", 32'(write_cnt), 2);
        check("busy_start_done_pulses", 32'(done_cnt), 1);

        // error is set, then cleared by the next start; reset mid WAIT_DONE
        load(t8(16'h1280, 16'h1101, 16'hFFFF, 0, 0, 0, 0, 0));
        fails_left[1] = 9;
        run(1000, "err_run");
        check("err_run_error", 32'(error), 1);
        check("err_run_errorIndex", 32'(errorIndex), 1);
        load(t8(16'h1280, 16'h1101, 16'hFFFF, 0, 0, 0, 0, 0));
        pulse_start();
        check("start_clears_error", 32'(error), 0);
        wait_state(ST_WAIT_DONE, 50, "mid_reset");
        reset = 1'b1;
        @(negedge clock); #1;
        check_reset_outputs("mid_reset");
        reset = 1'b0;
        busy_lo = 0; busy_hi = 3;
        load(t8(16'h1280, 16'h1101, 16'hFFFF, 0, 0, 0, 0, 0));
        run(1000, "after_reset");
        check("after_reset_writes", 32'(write_cnt), 2);
        check("after_reset_done_pulses", 32'(done_cnt), 1);

`ifdef I2C_READBACK_VERIFY_EN
        // readback of 12/80 returns 00 once: write+read of entry 0 repeated
        load(t8(16'h1280, 16'h1101, 16'hFFFF, 0, 0, 0, 0, 0));
        corrupt_left[0] = 1;
        run(1000, "verify");
        check("verify_writes", 32'(write_cnt), 3);
        check("verify_reads", 32'(read_cnt), 3);
        if (obs_q.size() > 1) check("verify_rewrite", 32'(obs_q[1]), 32'h1280);
        check("verify_done_pulses", 32'(done_cnt), 1);
        check("verify_error", 32'(error), 0);
`endif

        // randomized tables against the reference model
        for (int it = 0; it < 25; it++) begin
            string nm;
            int    k;
            logic [15:0] e, o;
            nm = $sformatf("rand%0d", it);
            obs_q.delete(); write_cnt = 0; read_cnt = 0; done_cnt = 0;
            for (int i = 0; i < NR; i++) begin
                if ($urandom_range(9, 0) == 0) rom[i] = 16'hFFFF;
                else rom[i] = {8'($urandom_range(253, 0)), 8'($urandom_range(255, 0))};
                k = int'($urandom_range(19, 0));
                fails_left[i] = (k < 13) ? 0 : (k < 18) ? int'($urandom_range(3, 1)) : int'($urandom_range(6, 4));
                corrupt_left[i] = 0;
                m_rom[i] = rom[i]; m_fail[i] = fails_left[i];
            end
            model_walk();
            run(2000, nm);
            check({nm, "_writes"}, 32'(obs_q.size()), 32'(exp_q.size()));
            while (exp_q.size() > 0 && obs_q.size() > 0) begin
                e = exp_q.pop_front(); o = obs_q.pop_front();
                check({nm, "_write_value"}, 32'(o), 32'(e));
            end
            check({nm, "_done_pulses"}, 32'(done_cnt), 32'(m_done));
            check({nm, "_error"}, 32'(error), 32'(m_err));
            if (m_err) check({nm, "_errorIndex"}, 32'(errorIndex), 32'(m_idx));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
